// File: rtl/bopit_round_ctrl_if.sv
// Bop-it round controller signal bundle: player inputs in, prompt and scores out.
// No latency of its own; carries plain levels and pulses only.
// No backpressure; every signal is a level or a single-cycle enable.
interface bopit_round_ctrl_if #(
  parameter int NSW     = 11,
  parameter int NBTN    = 4,
  parameter int SCORE_W = 7
);
  logic               tick;
  logic               start;
  logic               hard_mode;
  logic [NSW-1:0]     sw;
  logic [NBTN-1:0]    btn;
  logic [NSW-1:0]     led;
  logic [2:0]         letter;
  logic               busy;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] high_score;

  modport slave (
    input  tick, start, hard_mode, sw, btn,
    output led, letter, busy, game_over, score, last_score, high_score
  );

  modport master (
    output tick, start, hard_mode, sw, btn,
    input  led, letter, busy, game_over, score, last_score, high_score
  );
endinterface

// File: rtl/bopit_round_ctrl.sv
// Bop-it round controller: random prompt, tick-timed judgement, score keeping.
// Prompt valid two edges after inputs are released; the verdict lands on the sampling edge.
// No backpressure; a held input stalls the game in WAIT_REL.
module bopit_round_ctrl #(
  parameter int          NSW           = 11,
  parameter int          NBTN          = 4,
  parameter int          TIMEOUT_TICKS = 12,
  parameter int          SCORE_MAX     = 99,
  parameter int          SCORE_W       = 7,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  bopit_round_ctrl_if.slave bus
);

  localparam int T  = NSW + NBTN;
  localparam int TW = 5;
  localparam logic [7:0] LIM_NORM = 8'(TIMEOUT_TICKS);
  localparam logic [7:0] LIM_HARD = 8'(TIMEOUT_TICKS / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REL,
    S_PICK,
    S_PROMPT,
    S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [TW-1:0]      target_q, target_d;
  logic               prev_valid_q, prev_valid_d;
  logic [7:0]         timer_q, timer_d;
  logic [7:0]         limit_q, limit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] last_q, last_d;
  logic [SCORE_W-1:0] high_q, high_d;

  logic [T-1:0]       in_vec;
  logic [T-1:0]       tgt_onehot;
  logic               resp_hit;
  logic               resp_miss;
  logic [TW-1:0]      cand;
  logic [TW-1:0]      cand_inc;
  logic [7:0]         timer_inc;
  logic [SCORE_W-1:0] score_inc;

  assign in_vec     = {bus.btn, bus.sw};
  assign tgt_onehot = {{(T-1){1'b0}}, 1'b1} << target_q;
  assign resp_hit   = (in_vec == tgt_onehot);
  assign resp_miss  = (in_vec != '0) && !resp_hit;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand       = TW'(lfsr_q % T);
  assign cand_inc   = (cand == TW'(T - 1)) ? '0 : cand + TW'(1);
  assign timer_inc  = timer_q + 8'd1;
  assign score_inc  = (score_q >= SCORE_W'(SCORE_MAX)) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    prev_valid_d = prev_valid_q;
    timer_d      = timer_q;
    limit_d      = limit_q;
    score_d      = score_q;
    last_d       = last_q;
    high_d       = high_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT_REL;
          score_d = '0;
        end
      end
      S_WAIT_REL: begin
        if (in_vec == '0) state_d = S_PICK;
      end
      S_PICK: begin
        // Re-rolling onto the previous target just steps to the next one.
        target_d     = (prev_valid_q && cand == target_q) ? cand_inc : cand;
        prev_valid_d = 1'b1;
        limit_d      = bus.hard_mode ? LIM_HARD : LIM_NORM;
        timer_d      = '0;
        state_d      = S_PROMPT;
      end
      S_PROMPT: begin
        if (resp_hit) begin
          score_d = score_inc;
          state_d = S_WAIT_REL;
        end else if (resp_miss || (bus.tick && timer_inc == limit_q)) begin
          state_d = S_OVER;
          last_d  = score_q;
          high_d  = (score_q > high_q) ? score_q : high_q;
        end else if (bus.tick) begin
          timer_d = timer_inc;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          state_d = S_WAIT_REL;
          score_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      target_q     <= '0;
      prev_valid_q <= 1'b0;
      timer_q      <= '0;
      limit_q      <= LIM_NORM;
      score_q      <= '0;
      last_q       <= '0;
      high_q       <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      target_q     <= target_d;
      prev_valid_q <= prev_valid_d;
      timer_q      <= timer_d;
      limit_q      <= limit_d;
      score_q      <= score_d;
      last_q       <= last_d;
      high_q       <= high_d;
    end
  end

  assign bus.led        = (state_q == S_PROMPT && target_q < TW'(NSW)) ? tgt_onehot[NSW-1:0] : '0;
  assign bus.letter     = (state_q == S_PROMPT && target_q >= TW'(NSW))
                          ? 3'(target_q - TW'(NSW) + TW'(1)) : 3'd0;
  assign bus.busy       = (state_q == S_WAIT_REL) || (state_q == S_PICK) || (state_q == S_PROMPT);
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.score      = score_q;
  assign bus.last_score = last_q;
  assign bus.high_score = high_q;

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// Scoreboard bench for bopit_round_ctrl: predicts every prompt from an LFSR model
// and checks scores, timeouts, saturation and reset behaviour.
module tb_bopit_round_ctrl;
  localparam int NSW  = 11;
  localparam int NBTN = 4;
  localparam int T    = NSW + NBTN;
  localparam int SW   = 7;
  localparam int SMAX = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bopit_round_ctrl_if #(.NSW(NSW), .NBTN(NBTN), .SCORE_W(SW)) bus ();

  bopit_round_ctrl #(
    .NSW(NSW), .NBTN(NBTN), .TIMEOUT_TICKS(12), .SCORE_MAX(SMAX),
    .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  int checks = 0;
  int errors = 0;
  int tgt_q[$];
  int score_q[$];
  int prev_m;
  bit prev_valid_m;
  int cur_tgt;
  int last_obs;
  bit [T-1:0] seen;
  int model_score;
  int high_m;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input int idx);
    logic [T-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    bus.sw  = v[NSW-1:0];
    bus.btn = v[T-1:NSW];
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_led"},    int'(bus.led), 0);
    check({tag, "_letter"}, int'(bus.letter), 0);
    check({tag, "_busy"},   int'(bus.busy), 0);
    check({tag, "_over"},   int'(bus.game_over), 0);
    check({tag, "_score"},  int'(bus.score), 0);
    check({tag, "_last"},   int'(bus.last_score), 0);
    check({tag, "_high"},   int'(bus.high_score), 0);
  endtask

  // Called at a negedge with the DUT in WAIT_REL and all inputs released.
  task automatic expect_prompt();
    logic [15:0] nxt;
    int cand, t, obs, exp_led, exp_letter;
    nxt  = lfsr_step(lfsr_m);
    cand = int'(nxt) % T;
    t    = (prev_valid_m && cand == prev_m) ? (cand + 1) % T : cand;
    prev_m = t;
    prev_valid_m = 1'b1;
    tgt_q.push_back(t);
    @(negedge clk);
    check("pick_led", int'(bus.led), 0);
    check("pick_letter", int'(bus.letter), 0);
    @(negedge clk);
    cur_tgt    = tgt_q.pop_front();
    exp_led    = (cur_tgt < NSW) ? (1 << cur_tgt) : 0;
    exp_letter = (cur_tgt >= NSW) ? cur_tgt - NSW + 1 : 0;
    check("prompt_led", int'(bus.led), exp_led);
    check("prompt_letter", int'(bus.letter), exp_letter);
    obs = -1;
    if (bus.letter != 3'd0) obs = NSW + int'(bus.letter) - 1;
    else for (int i = 0; i < NSW; i++) if (bus.led[i] && $countones(bus.led) == 1) obs = i;
    if (last_obs >= 0) check("distinct", (obs != last_obs) ? 1 : 0, 1);
    last_obs = obs;
    if (obs >= 0) seen[obs] = 1'b1;
  endtask

  task automatic hit(input bit with_start, input bit with_tick);
    drive_in(cur_tgt);
    bus.start = with_start;
    bus.tick  = with_tick;
    model_score = (model_score < SMAX) ? model_score + 1 : SMAX;
    score_q.push_back(model_score);
    @(negedge clk);
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    check("hit_score", int'(bus.score), score_q.pop_front());
    check("hit_over", int'(bus.game_over), 0);
    check("hit_led", int'(bus.led), 0);
  endtask

  task automatic hit_next();
    hit(1'b0, 1'b0);
    drive_in(-1);
    expect_prompt();
  endtask

  task automatic start_game(input bit hard);
    bus.hard_mode = hard;
    bus.start = 1'b1;
    drive_in(-1);
    @(negedge clk);
    bus.start = 1'b0;
    model_score = 0;
    check("start_busy", int'(bus.busy), 1);
    check("start_score", int'(bus.score), 0);
    check("start_over", int'(bus.game_over), 0);
    expect_prompt();
  endtask

  task automatic over_bookkeeping();
    if (model_score > high_m) high_m = model_score;
    check("over_flag", int'(bus.game_over), 1);
    check("over_busy", int'(bus.busy), 0);
    check("over_led", int'(bus.led), 0);
    check("over_last", int'(bus.last_score), model_score);
    check("over_high", int'(bus.high_score), high_m);
  endtask

  task automatic wrong_end();
    logic [T-1:0] v;
    v = '0;
    v[cur_tgt] = 1'b1;
    v[(cur_tgt == 3) ? NSW + 2 : 3] = 1'b1;
    bus.sw  = v[NSW-1:0];
    bus.btn = v[T-1:NSW];
    @(negedge clk);
    over_bookkeeping();
    drive_in(-1);
  endtask

  task automatic timeout_end(input int limit);
    for (int i = 1; i <= limit; i++) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("to_over", int'(bus.game_over), (i == limit) ? 1 : 0);
      if (i < limit) repeat (3) @(negedge clk);
    end
    over_bookkeeping();
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.hard_mode = 1'b0;
    drive_in(-1);
    prev_valid_m = 1'b0;
    prev_m = 0;
    last_obs = -1;
    seen = '0;
    model_score = 0;
    high_m = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Game ending at 9 on a two-input wrong answer.
    start_game(1'b0);
    repeat (9) hit_next();
    wrong_end();

    // Game reaching 5, then reset while a prompt is up.
    start_game(1'b0);
    repeat (5) hit_next();
    check("pre_rst_score", int'(bus.score), 5);
    check("pre_rst_high", int'(bus.high_score), 9);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    model_score = 0;
    high_m = 0;
    prev_valid_m = 1'b0;
    last_obs = -1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("post_rst");

    // Long game: saturation at SCORE_MAX, then a normal-mode timeout.
    start_game(1'b0);
    seen = '0;
    hit(1'b1, 1'b0);
    drive_in(-1);
    expect_prompt();
    for (int r = 0; r < 204; r++) hit_next();
    check("coverage", $countones(seen), T);
    check("sat_score", int'(bus.score), SMAX);
    timeout_end(12);

    // Hard mode: short game, timeout on the sixth tick.
    start_game(1'b1);
    repeat (3) hit_next();
    timeout_end(6);

    // Hit on the final tick, held input stalls, then a wrong answer.
    start_game(1'b0);
    for (int i = 1; i < 12; i++) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("pre_tick_over", int'(bus.game_over), 0);
      repeat (3) @(negedge clk);
    end
    hit(1'b0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("held_led", int'(bus.led), 0);
      check("held_busy", int'(bus.busy), 1);
    end
    drive_in(-1);
    expect_prompt();
    wrong_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
